// File: rtl/des_decrypt_iter.sv
// Iterative DES engine: 16 Feistel rounds over 16/ROUNDS_PER_CLK clocks, subkeys generated on the fly.
// Optional macro DES_ENCRYPT_EN adds a "decrypt" port and the left-rotating encrypt key schedule.

module fFunction (
    input  logic [31:0] r,
    input  logic [47:0] subkey,
    output logic [31:0] f
);
    localparam int unsigned E_T [48] = '{
        32, 1, 2, 3, 4, 5,  4, 5, 6, 7, 8, 9,  8, 9,10,11,12,13, 12,13,14,15,16,17,
        16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32, 1};
    localparam int unsigned P_T [32] = '{
        16, 7,20,21,29,12,28,17, 1,15,23,26, 5,18,31,10,
         2, 8,24,14,32,27, 3, 9,19,13,30, 6,22,11, 4,25};
    localparam int unsigned SBOX [8][64] = '{
        '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,  0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
           4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0, 15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
        '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,  3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
           0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15, 13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
        '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
          13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,  1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
        '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15, 13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
          10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,  3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
        '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9, 14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
           4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14, 11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
        '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11, 10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
           9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,  4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
        '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1, 13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
           1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,  6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
        '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,  1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
           7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,  2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

    logic [47:0] x;
    logic [31:0] s;
    logic [5:0]  six;

    always_comb begin
        x = '0;
        for (int k = 0; k < 48; k++) x[47-k] = r[32-E_T[k]];
        x = x ^ subkey;
        s   = '0;
        six = '0;
        // S-box row is the outer bit pair, column the inner four bits
        for (int i = 0; i < 8; i++) begin
            six = x[47-6*i -: 6];
            s[31-4*i -: 4] = 4'(SBOX[i][{six[5], six[0], six[4:1]}]);
        end
        f = '0;
        for (int k = 0; k < 32; k++) f[31-k] = s[32-P_T[k]];
    end
endmodule

module des_decrypt_iter #(
    parameter int ROUNDS_PER_CLK = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
`ifdef DES_ENCRYPT_EN
    input  logic        decrypt,
`endif
    input  logic [63:0] data_in,
    input  logic [63:0] key_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] data_out
);
    localparam int unsigned IP_T [64] = '{
        58,50,42,34,26,18,10, 2, 60,52,44,36,28,20,12, 4, 62,54,46,38,30,22,14, 6, 64,56,48,40,32,24,16, 8,
        57,49,41,33,25,17, 9, 1, 59,51,43,35,27,19,11, 3, 61,53,45,37,29,21,13, 5, 63,55,47,39,31,23,15, 7};
    localparam int unsigned FP_T [64] = '{
        40, 8,48,16,56,24,64,32, 39, 7,47,15,55,23,63,31, 38, 6,46,14,54,22,62,30, 37, 5,45,13,53,21,61,29,
        36, 4,44,12,52,20,60,28, 35, 3,43,11,51,19,59,27, 34, 2,42,10,50,18,58,26, 33, 1,41, 9,49,17,57,25};
    localparam int unsigned PC1_T [56] = '{
        57,49,41,33,25,17, 9,  1,58,50,42,34,26,18, 10, 2,59,51,43,35,27, 19,11, 3,60,52,44,36,
        63,55,47,39,31,23,15,  7,62,54,46,38,30,22, 14, 6,61,53,45,37,29, 21,13, 5,28,20,12, 4};
    localparam int unsigned PC2_T [48] = '{
        14,17,11,24, 1, 5,  3,28,15, 6,21,10, 23,19,12, 4,26, 8, 16, 7,27,20,13, 2,
        41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic logic [63:0] perm_ip(input logic [63:0] x);
        logic [63:0] o;
        for (int k = 0; k < 64; k++) o[63-k] = x[64-IP_T[k]];
        return o;
    endfunction

    function automatic logic [63:0] perm_fp(input logic [63:0] x);
        logic [63:0] o;
        for (int k = 0; k < 64; k++) o[63-k] = x[64-FP_T[k]];
        return o;
    endfunction

    function automatic logic [55:0] perm_pc1(input logic [63:0] x);
        logic [55:0] o;
        for (int k = 0; k < 56; k++) o[55-k] = x[64-PC1_T[k]];
        return o;
    endfunction

    function automatic logic [47:0] perm_pc2(input logic [55:0] x);
        logic [47:0] o;
        for (int k = 0; k < 48; k++) o[47-k] = x[56-PC2_T[k]];
        return o;
    endfunction

    function automatic logic [1:0] shift_amt(input logic [4:0] n);
        return (n == 5'd1 || n == 5'd2 || n == 5'd9 || n == 5'd16) ? 2'd1 : 2'd2;
    endfunction

    function automatic logic [27:0] rot_r(input logic [27:0] x, input logic [1:0] n);
        case (n)
            2'd1:    return {x[0], x[27:1]};
            2'd2:    return {x[1:0], x[27:2]};
            default: return x;
        endcase
    endfunction

`ifdef DES_ENCRYPT_EN
    function automatic logic [27:0] rot_l(input logic [27:0] x, input logic [1:0] n);
        case (n)
            2'd1:    return {x[26:0], x[27]};
            2'd2:    return {x[25:0], x[27:26]};
            default: return x;
        endcase
    endfunction

    logic dec_mode;
`endif

    state_t      state, state_next;
    logic [31:0] l_half, r_half;
    logic [27:0] c_key, d_key;
    logic [4:0]  rcnt, rcnt_sum;

    logic [31:0] l_ch [ROUNDS_PER_CLK+1];
    logic [31:0] r_ch [ROUNDS_PER_CLK+1];
    logic [27:0] c_ch [ROUNDS_PER_CLK+1];
    logic [27:0] d_ch [ROUNDS_PER_CLK+1];

    assign l_ch[0]  = l_half;
    assign r_ch[0]  = r_half;
    assign c_ch[0]  = c_key;
    assign d_ch[0]  = d_key;
    assign rcnt_sum = rcnt + 5'(ROUNDS_PER_CLK);

    // Combinational chain of ROUNDS_PER_CLK rounds; round g of this clock is DES round rcnt+g+1
    for (genvar g = 0; g < ROUNDS_PER_CLK; g++) begin : g_round
        logic [4:0]  j;
        logic [1:0]  dec_amt;
        logic [27:0] c_rot, d_rot;
        logic [47:0] subkey;
        logic [31:0] f;

        assign j       = rcnt + 5'(g + 1);
        assign dec_amt = (j == 5'd1) ? 2'd0 : shift_amt(5'd18 - j);

        always_comb begin
            c_rot = rot_r(c_ch[g], dec_amt);
            d_rot = rot_r(d_ch[g], dec_amt);
`ifdef DES_ENCRYPT_EN
            if (!dec_mode) begin
                c_rot = rot_l(c_ch[g], shift_amt(j));
                d_rot = rot_l(d_ch[g], shift_amt(j));
            end
`endif
        end

        assign subkey = perm_pc2({c_rot, d_rot});

        fFunction u_f (
            .r      (r_ch[g]),
            .subkey (subkey),
            .f      (f)
        );

        assign c_ch[g+1] = c_rot;
        assign d_ch[g+1] = d_rot;
        assign l_ch[g+1] = r_ch[g];
        assign r_ch[g+1] = l_ch[g] ^ f;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                if (rcnt_sum == 5'd16) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_half   <= '0;
            r_half   <= '0;
            c_key    <= '0;
            d_key    <= '0;
            rcnt     <= '0;
            data_out <= '0;
`ifdef DES_ENCRYPT_EN
            dec_mode <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        {l_half, r_half} <= perm_ip(data_in);
                        {c_key, d_key}   <= perm_pc1(key_in);
                        rcnt             <= '0;
`ifdef DES_ENCRYPT_EN
                        dec_mode         <= decrypt;
`endif
                    end
                end
                RUN: begin
                    l_half <= l_ch[ROUNDS_PER_CLK];
                    r_half <= r_ch[ROUNDS_PER_CLK];
                    c_key  <= c_ch[ROUNDS_PER_CLK];
                    d_key  <= d_ch[ROUNDS_PER_CLK];
                    rcnt   <= rcnt_sum;
                    // Halves are swapped back before the final permutation
                    if (rcnt_sum == 5'd16)
                        data_out <= perm_fp({r_ch[ROUNDS_PER_CLK], l_ch[ROUNDS_PER_CLK]});
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_des_decrypt_iter.sv
// Scoreboard bench for des_decrypt_iter (default build, ROUNDS_PER_CLK=1).
module tb_des_decrypt_iter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] data_in = '0;
    logic [63:0] key_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] data_out;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] sb_q [$];

    always #5 clk = ~clk;

    des_decrypt_iter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .key_in    (key_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [63:0] ct, input logic [63:0] key, input logic [63:0] exp);
        @(negedge clk);
        check("in_ready_idle", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        data_in  = ct;
        key_in   = key;
        sb_q.push_back(exp);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        data_in  = ~ct;
        key_in   = ~key;
    endtask

    // hold: cycles out_ready stays low after completion; noisy: junk in_valid during RUN
    task automatic run_block(input logic [63:0] ct, input logic [63:0] key, input logic [63:0] exp,
                             input int hold, input bit noisy);
        int          lat;
        logic [63:0] snap;
        out_ready = (hold == 0);
        send(ct, key, exp);
        if (noisy) begin
            in_valid = 1'b1;
            data_in  = {$urandom, $urandom};
            key_in   = {$urandom, $urandom};
        end
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            check("in_ready_busy", 64'(in_ready), 64'd0);
        end
        if (noisy) in_valid = 1'b0;
        check("latency", 64'(lat), 64'd16);
        if (!out_valid) begin
            check("timeout_out_valid", 64'(out_valid), 64'd1);
            sb_q.delete();
            out_ready = 1'b1;
            return;
        end
        check("data_out", data_out, sb_q.pop_front());
        snap = data_out;
        if (hold > 0) begin
            in_valid = 1'b1;
            data_in  = {$urandom, $urandom};
            repeat (hold) begin
                @(posedge clk);
                #1;
                check("hold_out_valid", 64'(out_valid), 64'd1);
                check("hold_data_out", data_out, snap);
                check("hold_in_ready", 64'(in_ready), 64'd0);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check("post_out_valid", 64'(out_valid), 64'd0);
        check("post_in_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_data_out", data_out, 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        run_block(64'h85E813540F0AB405, 64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 0, 1'b0);
        run_block(64'h0000000000000000, 64'h0E329232EA6D0D73, 64'h8787878787878787, 0, 1'b1);
        run_block(64'h85E813540F0AB405, 64'h123556789ABDDEF0, 64'h0123456789ABCDEF, 0, 1'b0);
        run_block(64'h8CA64DE9C1B123A7, 64'h0000000000000000, 64'h0000000000000000, 0, 1'b0);
        run_block(64'h3FA40E8A984D4815, 64'h0123456789ABCDEF, 64'h4E6F772069732074, 0, 1'b1);
        run_block(64'h85E813540F0AB405, 64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 10, 1'b0);

        // Abort mid-run: outputs must drop to reset values immediately
        send(64'h0000000000000000, 64'h0E329232EA6D0D73, 64'h8787878787878787);
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_data_out", data_out, 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("abort_no_output", 64'(out_valid), 64'd0);

        run_block(64'h85E813540F0AB405, 64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 0, 1'b0);
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
